fetch_unit: RTL and testbench

- Instruction-fetch front end of the KGP-RISC core.
- Holds the program counter, issues word requests to instruction memory over a split request/response handshake, and buffers returned instructions in a 2-entry FIFO.
- The FIFO feeds the decode stage, whose input flops consume dec_instr/dec_pc.
- Branch/jump redirects from execute flush the buffer and restart fetch.

---
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem handshake, 2-entry decode buffer.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
`endif
    input  logic               dec_ready
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   req_pc_q;
    logic [1:0]          count_q;
    logic [INSTR_W-1:0]  instr0_q, instr1_q;
    logic [ADDR_W-1:0]   epc0_q, epc1_q;

    logic                granted;
    logic                push;
    logic                pop;
    logic                discard;
    logic [ADDR_W-1:0]   redirect_tgt;

    always_comb begin
        imem_req     = (state_q == StReq) && (count_q < 2'd2);
        imem_addr    = pc_q;
        granted      = imem_req && imem_gnt;
        push         = (state_q == StWait) && imem_rvalid && !redirect_valid;
        pop          = dec_valid && dec_ready && !redirect_valid;
        // Responses that arrive for a request made obsolete by a redirect.
        discard      = imem_rvalid &&
                       ((state_q == StDrop) || ((state_q == StWait) && redirect_valid));
        redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
        dec_valid    = (count_q != 2'd0);
        dec_instr    = instr0_q;
        dec_pc       = epc0_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            unique case (state_q)
                StIdle: state_q <= StReq;
                StReq: begin
                    if (granted) begin
                        req_pc_q <= pc_q;
                        state_q  <= redirect_valid ? StDrop : StWait;
                    end
                end
                StWait: begin
                    if (redirect_valid) begin
                        state_q <= imem_rvalid ? StReq : StDrop;
                    end else if (imem_rvalid) begin
                        state_q <= StReq;
                    end
                end
                StDrop: begin
                    if (imem_rvalid) begin
                        state_q <= StReq;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (redirect_valid) begin
                pc_q <= redirect_tgt;
            end else if (granted) begin
                pc_q <= pc_q + ADDR_W'(4);
            end
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 forward.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q  <= 2'd0;
            instr0_q <= '0;
            instr1_q <= '0;
            epc0_q   <= '0;
            epc1_q   <= '0;
        end else if (redirect_valid) begin
            count_q <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        instr0_q <= imem_rdata;
                        epc0_q   <= req_pc_q;
                    end else begin
                        instr1_q <= imem_rdata;
                        epc1_q   <= req_pc_q;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    instr0_q <= instr1_q;
                    epc0_q   <= epc1_q;
                    count_q  <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        instr0_q <= imem_rdata;
                        epc0_q   <= req_pc_q;
                    end else begin
                        instr0_q <= instr1_q;
                        epc0_q   <= epc1_q;
                        instr1_q <= imem_rdata;
                        epc1_q   <= req_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_flushed_q;
    logic [32:0] flushed_sum;

    always_comb begin
        flushed_sum = {1'b0, perf_flushed_q}
                    + (redirect_valid ? 33'(count_q) : 33'd0)
                    + 33'(discard);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (push && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            perf_flushed_q <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

    logic unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; covers reset, streaming, backpressure,
// redirects in WAIT and REQ+grant, PC wrap and reset while a request is outstanding.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int n_total = 0;
    int n_pass  = 0;

    fetch_unit #(
        .ADDR_W  (32),
        .INSTR_W (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dec_valid     (dec_valid),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched  (perf_fetched),
        .perf_flushed  (perf_flushed),
`endif
        .dec_ready     (dec_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic fetch_one(input logic [31:0] data);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hBAD0_BAD0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;

        // 1: reset held with stray responses
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_dvalid", 32'(dec_valid), 32'd0);
        end
        check("rst_instr", dec_instr, 32'h0);
        check("rst_pc", dec_pc, 32'h0);
        imem_rvalid = 1'b0;
        rst = 1'b1;
        tick();
        check("rel_req", 32'(imem_req), 32'd1);
        check("rel_addr", imem_addr, 32'h0);
        check("rel_dvalid", 32'(dec_valid), 32'd0);

        // 2: streaming, one request every two cycles
        dec_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            check("str_req", 32'(imem_req), 32'd1);
            check("str_addr", imem_addr, 32'(4 * n));
            fetch_one(32'hA0 + 32'(n));
            check("str_dvalid", 32'(dec_valid), 32'd1);
            check("str_dpc", dec_pc, 32'(4 * n));
            check("str_dinstr", dec_instr, 32'hA0 + 32'(n));
        end

        // 3: backpressure fills the buffer and stalls requests
        do_reset();
        dec_ready = 1'b0;
        fetch_one(32'hB0);
        check("bp_req1", 32'(imem_req), 32'd1);
        check("bp_addr1", imem_addr, 32'h4);
        fetch_one(32'hB1);
        check("bp_full_req", 32'(imem_req), 32'd0);
        check("bp_head_instr", dec_instr, 32'hB0);
        check("bp_head_pc", dec_pc, 32'h0);
        tick();
        check("bp_hold_req", 32'(imem_req), 32'd0);
        check("bp_hold_instr", dec_instr, 32'hB0);
        dec_ready = 1'b1;
        tick();
        check("bp_drain_pc", dec_pc, 32'h4);
        check("bp_drain_instr", dec_instr, 32'hB1);
        check("bp_resume_req", 32'(imem_req), 32'd1);
        check("bp_resume_addr", imem_addr, 32'h8);
        tick();
        check("bp_empty", 32'(dec_valid), 32'd0);
        check("bp_addr_keep", imem_addr, 32'h8);

        // 4: redirect while waiting, response arrives three cycles later
        do_reset();
        dec_ready = 1'b1;
        imem_gnt  = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 1'b0;
        check("rw_drop_req", 32'(imem_req), 32'd0);
        tick();
        check("rw_drop_req2", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD;
        tick();
        imem_rvalid = 1'b0;
        check("rw_dropped", 32'(dec_valid), 32'd0);
        check("rw_req", 32'(imem_req), 32'd1);
        check("rw_addr", imem_addr, 32'h100);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("rw_still_empty", 32'(dec_valid), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hC0;
        tick();
        imem_rvalid = 1'b0;
        check("rw_dvalid", 32'(dec_valid), 32'd1);
        check("rw_dpc", dec_pc, 32'h100);
        check("rw_dinstr", dec_instr, 32'hC0);

        // 5: redirect coincident with grant while one entry is buffered
        do_reset();
        dec_ready = 1'b0;
        fetch_one(32'hD0);
        check("rg_pre_valid", 32'(dec_valid), 32'd1);
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        check("rg_flushed", 32'(dec_valid), 32'd0);
        check("rg_drop_req", 32'(imem_req), 32'd0);
        tick();
        check("rg_drop_req2", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBEEF;
        tick();
        imem_rvalid = 1'b0;
        check("rg_req", 32'(imem_req), 32'd1);
        check("rg_addr", imem_addr, 32'h200);
        check("rg_empty", 32'(dec_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'd1);
        check("perf_flushed", perf_flushed, 32'd2);
`endif

        // 6: PC wrap, then reset while a request is outstanding
        do_reset();
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        check("wr_req", 32'(imem_req), 32'd1);
        fetch_one(32'hE0);
        check("wr_dpc", dec_pc, 32'hFFFF_FFFC);
        check("wr_dinstr", dec_instr, 32'hE0);
        check("wr_next_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b0;
        tick();
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD1;
        tick();
        imem_rvalid = 1'b0;
        check("mr_empty", 32'(dec_valid), 32'd0);
        check("mr_req", 32'(imem_req), 32'd1);
        check("mr_addr", imem_addr, 32'h0);
        tick();
        check("mr_still_empty", 32'(dec_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
